rob_dispatch_alloc: RTL and testbench
=====================================

Name: rob_dispatch_alloc

Overview:
Dispatch-side allocator that feeds the single-instruction reorder buffer. It accepts decoded instructions over a valid/ready handshake and assigns each one the next ROB entry. It drives the ROB's registered dispatch interface (dp1, dp1_addr, pc, dstvalid, dst). It tracks ROB occupancy from the ROB's per-cycle commit count and back-pressures decode when the ROB is full.

Parameters:
ROB_SEL, 6, width of ROB entry address
ROB_NUM, 64, ROB entries; entry 0 is never allocated, so 63 entries are usable
PC_LEN, 32, instruction PC width
REG_SEL, 5, architectural register index width

Ports:
clk_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous active-low reset
dec_valid_i  in  1  decode presents an instruction
dec_ready_o  out  1  allocator can accept this cycle
dec_pc_i  in  PC_LEN  instruction PC
dec_dstvalid_i  in  1  instruction writes a destination register
dec_dst_i  in  REG_SEL  destination register index
stall_i  in  1  downstream (reservation station) cannot take a dispatch
comnum_i  in  1  ROB committed one entry this cycle
dp1_o  out  1  dispatch strobe to ROB
dp1_addr_o  out  ROB_SEL  ROB entry allocated to the dispatched instruction
pc_dp1_o  out  PC_LEN  PC of the dispatched instruction
dstvalid_dp1_o  out  1  destination-valid of the dispatched instruction
dst_dp1_o  out  REG_SEL  destination register of the dispatched instruction
occ_o  out  ROB_SEL  number of allocated, uncommitted entries (0..63)
full_o  out  1  occ_o == 63
empty_o  out  1  occ_o == 0
underflow_o  out  1  sticky error flag: comnum_i was seen while occ_o == 0

Behaviour:
- Reset (asynchronous, reset_ni low) sets:
  - alloc_ptr=1, occ_o=0, dp1_o=0, dp1_addr_o=0, pc_dp1_o=0, dstvalid_dp1_o=0, dst_dp1_o=0, underflow_o=0.
  - full_o=0 and empty_o=1 (derived).
  - Asserting reset mid-operation discards any pending dispatch; dp1_o drops immediately.
- Readiness: dec_ready_o = !full_o & !stall_i. It is combinational from registered state and stall_i only, with no path from comnum_i. A commit in the same cycle does not make a full ROB ready.
- Accept = dec_valid_i & dec_ready_o. Decode may hold valid with stable payload while ready is low.
- Dispatch has 1-cycle latency. On the edge after accept:
  - dp1_o=1, dp1_addr_o=alloc_ptr.
  - pc/dstvalid/dst outputs take the accepted payload.
  - alloc_ptr advances.
  - If there is no accept, dp1_o=0 and the payload outputs hold their last values.
  - Back-to-back accepts give dp1_o high on consecutive cycles with consecutive addresses.
- Pointer wrap: alloc_ptr advances 1,2,…,63,1. The value 0 is never produced. This matches the ROB commit pointer, which also skips 0.
- Occupancy update: occ_next = occ + accept - (comnum_i & (occ != 0)).
  - Simultaneous accept and commit leave occ unchanged.
  - At occ=63, accept is impossible, so occ never exceeds 63.
- Underflow: comnum_i while occ==0 is ignored for counting and sets underflow_o. Only reset clears underflow_o.
- full_o, empty_o and underflow_o are registered-state-derived and never glitch on comnum_i.

Test Plan:
- Reset then idle. Hold reset_ni=0 for 2 cycles and release with dec_valid_i=0. Required: dp1_o=0, occ_o=0, empty_o=1, dec_ready_o=1, alloc_ptr at first dispatch = 1.
- Single dispatch. Drive dec_valid_i=1 for one cycle with pc=0x80000000, dst=5, dstvalid=1. Required, next cycle: dp1_o=1, dp1_addr_o=1, pc_dp1_o=0x80000000, dst_dp1_o=5, dstvalid_dp1_o=1, occ_o=1. dp1_o=0 the cycle after.
- Fill to full. Keep dec_valid_i=1 with comnum_i=0 for 70 cycles. Required:
  - 63 dispatches with addresses 1..63.
  - full_o=1 and dec_ready_o=0 after the 63rd.
  - No dp1_o pulses afterwards.
- Full with commit. At occ=63, pulse comnum_i=1 with dec_valid_i=1. Required:
  - No accept that cycle; occ_o=62 next cycle.
  - The next accept yields dp1_addr_o=1 (wrap from 63).
  - occ_o returns to 63.
- Simultaneous accept and commit at occ=10. Required: occ_o stays 10 and dp1_addr_o increments by 1.
- Stall, underflow and mid-operation reset:
  - stall_i=1 with dec_valid_i=1 gives dec_ready_o=0 and no dispatch.
  - comnum_i=1 at occ=0 gives underflow_o=1 and occ_o=0.
  - Asserting reset_ni=0 mid-burst immediately gives dp1_o=0, occ_o=0, underflow_o=0.

Source files
------------

// File: rtl/rob_dispatch_alloc.sv
// rob_dispatch_alloc: dispatch-side allocator for the single-issue reorder buffer.
// Takes one decoded instruction per cycle over valid/ready and hands it the next ROB entry.
// The dispatch is registered and sent one cycle later on the dp1 interface.
// It tracks ROB occupancy from the per-cycle commit strobe and back-pressures decode when the ROB is full.
//
// Ports:
//   clk_i, reset_ni                  clock (rising edge), async active-low reset
//   dec_valid_i / dec_ready_o        decode handshake
//   dec_pc_i, dec_dstvalid_i, dec_dst_i   decode payload
//   stall_i                          downstream cannot take a dispatch
//   comnum_i                         ROB committed one entry this cycle
//   dp1_o, dp1_addr_o, pc_dp1_o, dstvalid_dp1_o, dst_dp1_o   registered dispatch to ROB
//   occ_o, full_o, empty_o           occupancy and derived flags
//   underflow_o                      sticky: commit seen while empty
module rob_dispatch_alloc #(
    parameter int ROB_SEL = 6,
    parameter int ROB_NUM = 64,
    parameter int PC_LEN  = 32,
    parameter int REG_SEL = 5
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               dec_valid_i,
    output logic               dec_ready_o,
    input  logic [PC_LEN-1:0]  dec_pc_i,
    input  logic               dec_dstvalid_i,
    input  logic [REG_SEL-1:0] dec_dst_i,
    input  logic               stall_i,
    input  logic               comnum_i,
    output logic               dp1_o,
    output logic [ROB_SEL-1:0] dp1_addr_o,
    output logic [PC_LEN-1:0]  pc_dp1_o,
    output logic               dstvalid_dp1_o,
    output logic [REG_SEL-1:0] dst_dp1_o,
    output logic [ROB_SEL-1:0] occ_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               underflow_o
);

    // Entry 0 is reserved, so the last usable entry doubles as the capacity.
    localparam logic [ROB_SEL-1:0] LAST = ROB_SEL'(ROB_NUM - 1);
    localparam logic [ROB_SEL-1:0] ONE  = ROB_SEL'(1);

    logic [ROB_SEL-1:0] alloc_ptr;
    logic [ROB_SEL-1:0] occ;
    logic               accept;
    logic               commit;

    assign full_o      = (occ == LAST);
    assign empty_o     = (occ == '0);
    assign occ_o       = occ;
    // Ready depends only on registered occupancy and stall; a same-cycle
    // commit never opens a full ROB.
    assign dec_ready_o = !full_o && !stall_i;
    assign accept      = dec_valid_i && dec_ready_o;
    // A commit while empty is bogus: it is flagged but not counted.
    assign commit      = comnum_i && !empty_o;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            alloc_ptr      <= ONE;
            occ            <= '0;
            dp1_o          <= 1'b0;
            dp1_addr_o     <= '0;
            pc_dp1_o       <= '0;
            dstvalid_dp1_o <= 1'b0;
            dst_dp1_o      <= '0;
            underflow_o    <= 1'b0;
        end else begin
            dp1_o <= accept;
            if (accept) begin
                dp1_addr_o     <= alloc_ptr;
                pc_dp1_o       <= dec_pc_i;
                dstvalid_dp1_o <= dec_dstvalid_i;
                dst_dp1_o      <= dec_dst_i;
                // Wrap 63 -> 1 to stay in step with the ROB commit pointer.
                alloc_ptr      <= (alloc_ptr == LAST) ? ONE : alloc_ptr + ONE;
            end
            if (accept && !commit)
                occ <= occ + ONE;
            else if (!accept && commit)
                occ <= occ - ONE;
            if (comnum_i && empty_o)
                underflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rob_dispatch_alloc.sv
// Self-checking bench for rob_dispatch_alloc.
// The reference model keeps a queue of allocated ROB entries. Occupancy is the queue size,
// a commit pops the oldest entry and a dispatch pushes the allocated pointer.
module tb_rob_dispatch_alloc;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        dec_valid_i;
    logic        dec_ready_o;
    logic [31:0] dec_pc_i;
    logic        dec_dstvalid_i;
    logic [4:0]  dec_dst_i;
    logic        stall_i;
    logic        comnum_i;
    logic        dp1_o;
    logic [5:0]  dp1_addr_o;
    logic [31:0] pc_dp1_o;
    logic        dstvalid_dp1_o;
    logic [4:0]  dst_dp1_o;
    logic [5:0]  occ_o;
    logic        full_o;
    logic        empty_o;
    logic        underflow_o;

    rob_dispatch_alloc dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_pc_i(dec_pc_i), .dec_dstvalid_i(dec_dstvalid_i), .dec_dst_i(dec_dst_i),
        .stall_i(stall_i), .comnum_i(comnum_i),
        .dp1_o(dp1_o), .dp1_addr_o(dp1_addr_o), .pc_dp1_o(pc_dp1_o),
        .dstvalid_dp1_o(dstvalid_dp1_o), .dst_dp1_o(dst_dp1_o),
        .occ_o(occ_o), .full_o(full_o), .empty_o(empty_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    int          rob_q[$];
    int          ptr;
    logic        e_dp1, e_dv, e_under;
    logic [5:0]  e_addr;
    logic [31:0] e_pc;
    logic [4:0]  e_dst;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rob_q.delete();
        ptr = 1; e_dp1 = 0; e_addr = 0; e_pc = 0; e_dv = 0; e_dst = 0; e_under = 0;
    endtask

    task automatic check_all();
        chk("dp1", dp1_o, e_dp1);
        chk("dp1_addr", dp1_addr_o, e_addr);
        chk("pc_dp1", pc_dp1_o, e_pc);
        chk("dstvalid_dp1", dstvalid_dp1_o, e_dv);
        chk("dst_dp1", dst_dp1_o, e_dst);
        chk("occ", occ_o, rob_q.size());
        chk("full", full_o, rob_q.size() == 63);
        chk("empty", empty_o, rob_q.size() == 0);
        chk("underflow", underflow_o, e_under);
    endtask

    // Called at a negedge: drive inputs, check ready, advance model across
    // the posedge, then check registered outputs on the next negedge.
    task automatic step(input logic v, input logic [31:0] pc, input logic dv,
                        input logic [4:0] dst, input logic st, input logic cm);
        logic rdy, acc;
        dec_valid_i = v; dec_pc_i = pc; dec_dstvalid_i = dv; dec_dst_i = dst;
        stall_i = st; comnum_i = cm;
        #1;
        rdy = (rob_q.size() != 63) && !st;
        acc = v && rdy;
        chk("dec_ready", dec_ready_o, rdy);
        @(posedge clk_i);
        if (cm) begin
            if (rob_q.size() == 0) e_under = 1;
            else void'(rob_q.pop_front());
        end
        e_dp1 = acc;
        if (acc) begin
            rob_q.push_back(ptr);
            e_addr = 6'(ptr); e_pc = pc; e_dv = dv; e_dst = dst;
            ptr = (ptr == 63) ? 1 : ptr + 1;
        end
        @(negedge clk_i);
        check_all();
    endtask

    task automatic do_reset();
        dec_valid_i = 0; dec_pc_i = 0; dec_dstvalid_i = 0; dec_dst_i = 0;
        stall_i = 0; comnum_i = 0;
        reset_ni = 0;
        repeat (2) @(negedge clk_i);
        model_reset();
        reset_ni = 1;
        #1;
        check_all();
    endtask

    initial begin
        int pulses;
        logic ok_seq;
        reset_ni = 1;
        @(negedge clk_i);

        // reset then idle
        do_reset();
        chk("rst_occ_lit", occ_o, 0);
        chk("rst_empty_lit", empty_o, 1);
        chk("rst_ready_lit", dec_ready_o, 1);
        step(0, 0, 0, 0, 0, 0);

        // single dispatch
        step(1, 32'h8000_0000, 1, 5, 0, 0);
        chk("single_dp1_lit", dp1_o, 1);
        chk("single_addr_lit", dp1_addr_o, 1);
        chk("single_pc_lit", pc_dp1_o, 32'h8000_0000);
        chk("single_dst_lit", dst_dp1_o, 5);
        chk("single_occ_lit", occ_o, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("single_drop_lit", dp1_o, 0);

        // fill to full from reset
        do_reset();
        pulses = 0; ok_seq = 1;
        for (int i = 0; i < 70; i++) begin
            step(1, 32'h1000 + i * 4, i[0], 5'(i), 0, 0);
            if (dp1_o) begin
                pulses++;
                if (dp1_addr_o != 6'(pulses)) ok_seq = 0;
            end
        end
        chk("fill_pulses_lit", pulses, 63);
        chk("fill_addr_seq", ok_seq, 1);
        chk("fill_full_lit", full_o, 1);
        #1 chk("fill_ready_lit", dec_ready_o, 0);

        // full with commit: no accept, then wrap to entry 1
        step(1, 32'hABCD, 1, 7, 0, 1);
        chk("fullcm_dp1_lit", dp1_o, 0);
        chk("fullcm_occ_lit", occ_o, 62);
        step(1, 32'hABCD, 1, 7, 0, 0);
        chk("wrap_addr_lit", dp1_addr_o, 1);
        chk("wrap_occ_lit", occ_o, 63);

        // simultaneous accept and commit at occ=10
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 32'(i), 0, 0, 0, 0);
        step(1, 32'h55, 1, 3, 0, 1);
        chk("simul_occ_lit", occ_o, 10);
        chk("simul_addr_lit", dp1_addr_o, 11);

        // stall
        step(1, 32'h66, 1, 4, 1, 0);
        chk("stall_dp1_lit", dp1_o, 0);

        // underflow
        do_reset();
        step(0, 0, 0, 0, 0, 1);
        chk("under_flag_lit", underflow_o, 1);
        chk("under_occ_lit", occ_o, 0);

        // mid-burst async reset
        for (int i = 0; i < 4; i++) step(1, 32'(i), 1, 1, 0, 0);
        chk("preburst_dp1_lit", dp1_o, 1);
        #2 reset_ni = 0;
        #1;
        chk("midrst_dp1_lit", dp1_o, 0);
        chk("midrst_occ_lit", occ_o, 0);
        chk("midrst_under_lit", underflow_o, 0);
        @(negedge clk_i);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic v, st, cm;
            v  = ($urandom_range(0, 9) < 8);
            st = ($urandom_range(0, 9) == 0);
            // alternate commit-light and commit-heavy phases to reach full and empty
            cm = ((i / 300) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 9);
            step(v, $urandom, 1'($urandom), 5'($urandom), st, cm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
